// File: rtl/div_sequencer.sv
// Multi-cycle 32-bit DIV/DIVU sequencer for the execute stage.
// Runs a restoring shift-subtract loop and stalls the pipeline until done.
module div_sequencer (
    input  logic        clk,
    input  logic        rst,
    input  logic        signed_div_i,
    input  logic [31:0] opdata1_i,
    input  logic [31:0] opdata2_i,
    input  logic        start_i,
    input  logic        annul_i,
    output logic [63:0] result_o,
    output logic        ready_o,
    output logic        stallreq_o
);

    typedef enum logic [1:0] {
        S_FREE,
        S_DIVZERO,
        S_ON,
        S_END
    } state_t;

    state_t      state;
    logic [5:0]  cnt;
    logic [64:0] work;
    logic [31:0] divisor;
    logic        sgn;
    logic        sign1;
    logic        sign2;

    logic [31:0] mag1;
    logic [31:0] mag2;
    logic [32:0] diff;
    logic [31:0] quot;
    logic [31:0] rem;
    logic [31:0] quot_fix;
    logic [31:0] rem_fix;

    // Operand magnitudes; unsigned requests pass straight through.
    assign mag1 = (signed_div_i && opdata1_i[31]) ? 32'd0 - opdata1_i
                                                  : opdata1_i;
    assign mag2 = (signed_div_i && opdata2_i[31]) ? 32'd0 - opdata2_i
                                                  : opdata2_i;

    assign diff = {1'b0, work[63:32]} - {1'b0, divisor};

    assign quot = work[31:0];
    assign rem  = work[64:33];

    // Quotient truncates toward zero; remainder follows the dividend sign.
    assign quot_fix = (sgn && (sign1 ^ sign2)) ? 32'd0 - quot : quot;
    assign rem_fix  = (sgn && sign1) ? 32'd0 - rem : rem;

    assign stallreq_o = !rst && !annul_i &&
                        ((state == S_FREE && start_i) ||
                         state == S_DIVZERO ||
                         state == S_ON);

    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= S_FREE;
            cnt      <= 6'd0;
            work     <= 65'd0;
            divisor  <= 32'd0;
            sgn      <= 1'b0;
            sign1    <= 1'b0;
            sign2    <= 1'b0;
            result_o <= 64'd0;
            ready_o  <= 1'b0;
        end else begin
            unique case (state)
                S_FREE: begin
                    if (start_i && !annul_i) begin
                        sgn   <= signed_div_i;
                        sign1 <= opdata1_i[31];
                        sign2 <= opdata2_i[31];
                        cnt   <= 6'd0;
                        if (opdata2_i == 32'd0) begin
                            state <= S_DIVZERO;
                        end else begin
                            state   <= S_ON;
                            work    <= {32'd0, mag1, 1'b0};
                            divisor <= mag2;
                        end
                    end
                end
                S_DIVZERO: begin
                    if (annul_i) begin
                        state    <= S_FREE;
                        cnt      <= 6'd0;
                        result_o <= 64'd0;
                        ready_o  <= 1'b0;
                    end else begin
                        state    <= S_END;
                        result_o <= 64'd0;
                        ready_o  <= 1'b1;
                    end
                end
                S_ON: begin
                    if (annul_i) begin
                        state    <= S_FREE;
                        cnt      <= 6'd0;
                        result_o <= 64'd0;
                        ready_o  <= 1'b0;
                    end else if (cnt != 6'd32) begin
                        if (diff[32]) begin
                            work <= {work[63:0], 1'b0};
                        end else begin
                            work <= {diff[31:0], work[31:0], 1'b1};
                        end
                        cnt <= cnt + 6'd1;
                    end else begin
                        state    <= S_END;
                        cnt      <= 6'd0;
                        result_o <= {rem_fix, quot_fix};
                        ready_o  <= 1'b1;
                    end
                end
                S_END: begin
                    if (annul_i || !start_i) begin
                        state    <= S_FREE;
                        cnt      <= 6'd0;
                        result_o <= 64'd0;
                        ready_o  <= 1'b0;
                    end
                end
                default: begin
                    state    <= S_FREE;
                    cnt      <= 6'd0;
                    result_o <= 64'd0;
                    ready_o  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_div_sequencer.sv
// Scoreboard bench for div_sequencer: directed divisions with
// hand-computed results, latency, annul and reset checks.
module tb_div_sequencer;

    logic        clk;
    logic        rst;
    logic        signed_div_i;
    logic [31:0] opdata1_i;
    logic [31:0] opdata2_i;
    logic        start_i;
    logic        annul_i;
    logic [63:0] result_o;
    logic        ready_o;
    logic        stallreq_o;

    typedef struct {
        logic [63:0] res;
        int          at;
    } exp_t;

    exp_t sb[$];
    exp_t mon_e;
    int   checks = 0;
    int   errors = 0;
    int   ecount = 0;
    logic ready_q = 1'b0;

    div_sequencer dut (
        .clk          (clk),
        .rst          (rst),
        .signed_div_i (signed_div_i),
        .opdata1_i    (opdata1_i),
        .opdata2_i    (opdata2_i),
        .start_i      (start_i),
        .annul_i      (annul_i),
        .result_o     (result_o),
        .ready_o      (ready_o),
        .stallreq_o   (stallreq_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) ecount <= ecount + 1;

    task automatic chk(input string name, input logic [63:0] act,
                       input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Monitor: every rising ready_o must match the next queued result.
    always @(negedge clk) begin
        if (ready_o && !ready_q) begin
            if (sb.size() == 0) begin
                chk("unexpected_ready", {63'd0, ready_o}, 64'd0);
            end else begin
                mon_e = sb.pop_front();
                chk("result", result_o, mon_e.res);
                chk("ready_cycle", 64'(ecount), 64'(mon_e.at));
            end
        end
        ready_q <= ready_o;
    end

    task automatic run_div(input logic sgn, input logic [31:0] a,
                           input logic [31:0] b, input logic [63:0] exp,
                           input int lat, input string name);
        int t0;
        int guard;
        logic bad;
        @(negedge clk);
        signed_div_i = sgn;
        opdata1_i    = a;
        opdata2_i    = b;
        start_i      = 1'b1;
        annul_i      = 1'b0;
        t0 = ecount;
        sb.push_back('{exp, t0 + lat});
        bad = 1'b0;
        for (int k = 0; k < lat; k++) begin
            if (k > 0) @(negedge clk);
            #1;
            if (k == 1) begin
                opdata1_i    = $urandom;
                opdata2_i    = $urandom;
                signed_div_i = ~sgn;
            end
            if (stallreq_o !== 1'b1 || ready_o !== 1'b0) bad = 1'b1;
        end
        chk({name, "_stall_window"}, {63'd0, bad}, 64'd0);
        guard = 0;
        while (!ready_o && guard < 60) begin
            @(negedge clk);
            #1;
            guard++;
        end
        chk({name, "_ready_seen"}, {63'd0, ready_o}, 64'd1);
        chk({name, "_stall_at_ready"}, {63'd0, stallreq_o}, 64'd0);
        @(negedge clk);
        #1;
        chk({name, "_hold"}, {ready_o, result_o[62:0]}, {1'b1, exp[62:0]});
        start_i = 1'b0;
        @(negedge clk);
        #1;
        chk({name, "_clear"}, {63'd0, ready_o} | result_o, 64'd0);
    endtask

    task automatic quiet(input int n, input string name);
        logic bad;
        bad = 1'b0;
        for (int k = 0; k < n; k++) begin
            @(negedge clk);
            #1;
            if (ready_o !== 1'b0 || stallreq_o !== 1'b0) bad = 1'b1;
        end
        chk(name, {63'd0, bad}, 64'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL global_timeout: got running expected finished");
        $fatal(1, "timeout");
    end

    initial begin
        rst          = 1'b1;
        signed_div_i = 1'b0;
        opdata1_i    = 32'd0;
        opdata2_i    = 32'd0;
        start_i      = 1'b0;
        annul_i      = 1'b0;
        repeat (3) @(negedge clk);
        #1;
        chk("reset_result", result_o, 64'd0);
        chk("reset_ready", {63'd0, ready_o}, 64'd0);
        start_i = 1'b1;
        #1;
        chk("reset_stall", {63'd0, stallreq_o}, 64'd0);
        @(negedge clk);
        start_i = 1'b0;
        rst     = 1'b0;

        run_div(1'b0, 32'd100, 32'd7, {32'd2, 32'd14}, 34, "u100_7");
        run_div(1'b1, 32'hFFFFFFF9, 32'h2,
                {32'hFFFFFFFF, 32'hFFFFFFFD}, 34, "sm7_2");
        run_div(1'b1, 32'h7, 32'hFFFFFFFE,
                {32'h00000001, 32'hFFFFFFFD}, 34, "s7_m2");
        run_div(1'b1, 32'hFFFFFF9C, 32'hFFFFFFF9,
                {32'hFFFFFFFE, 32'h0000000E}, 34, "sm100_m7");
        run_div(1'b0, 32'h12345678, 32'd0, 64'd0, 2, "divzero");
        run_div(1'b1, 32'h80000000, 32'hFFFFFFFF,
                {32'd0, 32'h80000000}, 34, "s_overflow");
        run_div(1'b0, 32'hFFFFFFFF, 32'd1,
                {32'd0, 32'hFFFFFFFF}, 34, "u_max_1");
        run_div(1'b0, 32'd5, 32'd9, {32'd5, 32'd0}, 34, "u5_9");

        // Annul in the middle of a division.
        @(negedge clk);
        signed_div_i = 1'b0;
        opdata1_i    = 32'hFFFFFFFF;
        opdata2_i    = 32'd3;
        start_i      = 1'b1;
        repeat (10) @(negedge clk);
        annul_i = 1'b1;
        start_i = 1'b0;
        #1;
        chk("annul_stall", {63'd0, stallreq_o}, 64'd0);
        @(negedge clk);
        annul_i = 1'b0;
        #1;
        chk("annul_free", {62'd0, ready_o, stallreq_o} | result_o, 64'd0);
        quiet(40, "annul_no_ready");
        run_div(1'b0, 32'd9, 32'd3, {32'd0, 32'd3}, 34, "u9_3");

        // Synchronous reset in the middle of a division.
        @(negedge clk);
        signed_div_i = 1'b0;
        opdata1_i    = 32'd1000;
        opdata2_i    = 32'd3;
        start_i      = 1'b1;
        repeat (15) @(negedge clk);
        rst = 1'b1;
        #1;
        chk("rst_mid_stall", {63'd0, stallreq_o}, 64'd0);
        @(negedge clk);
        start_i = 1'b0;
        #1;
        chk("rst_mid_out", {63'd0, ready_o} | result_o, 64'd0);
        rst = 1'b0;
        quiet(40, "rst_no_ready");
        run_div(1'b0, 32'd21, 32'd4, {32'd1, 32'd5}, 34, "u21_4");

        repeat (3) @(negedge clk);
        chk("scoreboard_empty", 64'(sb.size()), 64'd0);
        $display("Simulation finished: %0d checks, %0d errors",
                 checks, errors);
        $finish;
    end

endmodule

// File: doc/div_sequencer.md
# div_sequencer

Multi-cycle divide sequencer for the OpenMIPS execute stage. It accepts a DIV/DIVU request from EX and runs a 32-step shift-subtract division over about 34 cycles, holding the pipeline with a stall request until the result is ready. It returns `{remainder, quotient}` for the HI/LO write path. EX owns the handshake; the pipeline control block consumes `stallreq_o`.

## Interface
- No parameters; width is fixed at 32 bits per operand.
- `clk`  in  1  system clock; all state updates on its rising edge.
- `rst`  in  1  synchronous, active-high reset (`RstEnable` = 1'b1).
- `signed_div_i`  in  1  1 = DIV (signed), 0 = DIVU.
- `opdata1_i`  in  32  dividend.
- `opdata2_i`  in  32  divisor.
- `start_i`  in  1  request level from EX; held high until the result is consumed.
- `annul_i`  in  1  cancel request (flush or exception); overrides `start_i`.
- `result_o`  out  64  `{remainder[63:32], quotient[31:0]}`; valid while `ready_o`=1.
- `ready_o`  out  1  result valid (registered).
- `stallreq_o`  out  1  pipeline stall request (combinational).

## Operation
- **States:**
  - FREE (reset state), DIVZERO, ON, END.
  - 6-bit step counter `cnt`.
- **FREE:**
  - On `start_i`=1 and `annul_i`=0, latch operands, `signed_div_i` and the sign bits.
  - If `opdata2_i`=0, go to DIVZERO.
  - Otherwise go to ON with `cnt`=0. In that case, if signed, the working operands are the two's-complement magnitudes of any negative operand.
- **DIVZERO:** go to END with `result_o` = 64'h0.
- **ON, cnt < 32:**
  - One restoring step per cycle on a 65-bit working register W, where W[32:1] is initialised to the dividend magnitude and all other bits of W are 0.
  - Compute t = {1'b0, W[63:32]} − {1'b0, divisor}.
  - If t[32] = 1: W <= {W[63:0], 1'b0}.
  - Else: W <= {t[31:0], W[31:0], 1'b1}.
  - Then `cnt`++.
- **ON, cnt = 32:**
  - quotient = W[31:0], remainder = W[64:33].
  - If signed and dividend sign ≠ divisor sign, negate the quotient.
  - If signed and the dividend is negative, negate the remainder.
  - Register the result into `result_o`, set `ready_o`=1, go to END.
- **END:**
  - Hold `result_o` and `ready_o` while `start_i`=1.
  - When `start_i`=0, go to FREE, clear `ready_o` and `result_o` to 0.
- **Annul:** `annul_i`=1 in DIVZERO, ON or END forces FREE on the next edge, with `ready_o`=0, `result_o`=0 and `cnt`=0.
- **`stallreq_o`:** 1 when (state = FREE and `start_i`=1 and `annul_i`=0), or state ∈ {DIVZERO, ON}. It is 0 in END and whenever `annul_i`=1.
- **Operand stability:** inputs may change after the start cycle; only latched copies are used.
- **Overflow case:** signed 0x80000000 / 0xFFFFFFFF gives quotient 0x80000000, remainder 0 (mod-2^32 wrap, no trap).
- **Rounding:** quotient truncates toward zero; a nonzero remainder takes the sign of the dividend.

## Timing
- **Reset:** while `rst`=1 at an edge, state = FREE, `cnt`=0, `result_o`=64'h0, `ready_o`=0. `stallreq_o` evaluates to 0 while reset is asserted.
- **Latency:** start sampled at edge 0. ON occupies edges 1..33 (33 cycles), and `ready_o` rises after edge 33, so the result is visible in cycle 34.
  - `stallreq_o` is high from cycle 0 through cycle 33.
  - EX proceeds in cycle 34.
- **Divide by zero:** `ready_o`=1 in cycle 2; stall high in cycles 0–1.
- **Back-to-back:** after END, FREE needs one cycle with `start_i`=0 before a new request is accepted.
- **Reset mid-operation:** returns to FREE at that edge; any partial result is discarded.
- **Simultaneous `start_i` and `annul_i` in FREE:** the request is ignored and the stall stays low.

## Test plan
- Unsigned 100 / 7 (`signed_div_i`=0), `start_i` held → `stallreq_o` high in cycles 0–33; `ready_o`=1 at cycle 34 with `result_o` = {32'd2, 32'd14}.
- Signed −7 / 2 (0xFFFFFFF9, 0x2) → `result_o` = {0xFFFFFFFF, 0xFFFFFFFD}. Also signed 7 / −2 → {0x00000001, 0xFFFFFFFD}.
- Divide by zero, 0x12345678 / 0 → `ready_o`=1 at cycle 2, `result_o` = 0; drop `start_i` → FREE next cycle with `ready_o`=0.
- Start 0xFFFFFFFF / 3 unsigned, assert `annul_i` at cycle 10 → FREE at cycle 11, `stallreq_o`=0 from cycle 10, `ready_o` never rises. A fresh 9 / 3 then yields {0, 3} at cycle 34 relative to its own start.
- Edge operands:
  - Signed 0x80000000 / 0xFFFFFFFF → {0, 0x80000000}.
  - Unsigned 0xFFFFFFFF / 1 → {0, 0xFFFFFFFF}.
  - Unsigned 5 / 9 → {5, 0}.
- Synchronous `rst` pulse at cycle 15 of a division → all outputs 0 at the next edge, and the state returns to FREE.
